// File: rtl/counter_bus_pkg.sv
// Shared types and helpers for the counter bus reader.
//   state_e  : reader FSM state encoding
//   DefNSrc  : default number of counters on the shared bus
//   DefDataW : default shared bus width
//   onehot() : index to one-hot strobe vector (up to MaxSrc sources)
package counter_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StGap,
        StHold
    } state_e;

    localparam int unsigned DefNSrc  = 2;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned MaxSrc   = 8;

    function automatic logic [MaxSrc-1:0] onehot(input logic [2:0] idx);
        logic [MaxSrc-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin source picker (purely combinational).
//   mask_i  : sources eligible for polling
//   ptr_i   : index of the source served last
//   sel_o   : lowest eligible index above ptr_i, wrapping modulo N_SRC
//   found_o : at least one source is eligible
module rr_next_sel #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned IdW   = 1
) (
    input  logic [N_SRC-1:0] mask_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic [IdW-1:0]   sel_o,
    output logic             found_o
);

    int unsigned      sum;
    logic [IdW-1:0]   idx;

    // Walk from the farthest candidate back to the nearest, so the nearest
    // eligible source after the pointer overwrites any earlier hit.
    always_comb begin
        sel_o   = '0;
        found_o = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned k = N_SRC; k >= 1; k--) begin
            sum = 32'(ptr_i) + k;
            if (sum >= N_SRC) begin
                sum = sum - N_SRC;
            end
            idx = IdW'(sum);
            if (mask_i[idx]) begin
                sel_o   = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_bus_reader.sv
// Round-robin reader for counters sharing one tristate data bus.
//   clk, reset_b          : clock, async active-low reset
//   poll_en, src_mask     : polling enable and per-counter poll mask
//   bus_data              : shared bus as seen by the reader
//   rd_o                  : registered one-hot (or zero) read strobes
//   out_valid/out_ready   : output handshake for captured samples
//   out_id, out_data      : source index and captured bus value
//   busy                  : high whenever not idle
module counter_bus_reader
    import counter_bus_pkg::*;
#(
    parameter int unsigned N_SRC      = DefNSrc,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned RD_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     poll_en,
    input  logic [N_SRC-1:0]         src_mask,
    input  logic [DATA_W-1:0]        bus_data,
    output logic [N_SRC-1:0]         rd_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_SRC)-1:0] out_id,
    output logic [DATA_W-1:0]        out_data,
    output logic                     busy
);

    localparam int unsigned IdW    = $clog2(N_SRC);
    localparam int unsigned CntMax = (RD_CYCLES > GAP_CYCLES) ? RD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] RdLoad  = CntW'(RD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [IdW-1:0]      sel_q;
    logic [IdW-1:0]      ptr_q;
    logic [N_SRC-1:0]    rd_q;
    logic                out_valid_q;
    logic [IdW-1:0]      out_id_q;
    logic [DATA_W-1:0]   out_data_q;

    logic [IdW-1:0]      next_sel;
    logic                found;
    logic [MaxSrc-1:0]   next_oh;
    logic                slot_free;
    logic                can_start;

    rr_next_sel #(
        .N_SRC (N_SRC),
        .IdW   (IdW)
    ) u_rr_next_sel (
        .mask_i  (src_mask),
        .ptr_i   (ptr_q),
        .sel_o   (next_sel),
        .found_o (found)
    );

    assign next_oh = onehot(3'(next_sel));

    // A transfer on this edge frees the slot for a selection on the same edge.
    assign slot_free = !out_valid_q || out_ready;
    assign can_start = poll_en && found && slot_free;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= IdW'(N_SRC - 1);
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle, StHold: begin
                    if (can_start) begin
                        sel_q   <= next_sel;
                        rd_q    <= next_oh[N_SRC-1:0];
                        cnt_q   <= RdLoad;
                        state_q <= StRead;
                    end else if (slot_free) begin
                        state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (cnt_q == '0) begin
                        out_data_q  <= bus_data;
                        out_id_q    <= sel_q;
                        out_valid_q <= 1'b1;
                        rd_q        <= '0;
                        ptr_q       <= sel_q;
                        cnt_q       <= GapLoad;
                        state_q     <= StGap;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (can_start) begin
                        sel_q   <= next_sel;
                        rd_q    <= next_oh[N_SRC-1:0];
                        cnt_q   <= RdLoad;
                        state_q <= StRead;
                    end else if (!slot_free) begin
                        state_q <= StHold;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_o      = rd_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_counter_bus_reader.sv
// Self-checking bench for counter_bus_reader: transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_counter_bus_reader;

    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int RD  = 2;
    localparam int GAP = 1;

    logic          clk;
    logic          reset_b;
    logic          poll_en;
    logic [N-1:0]  src_mask;
    wire  [DW-1:0] bus_data;
    logic [N-1:0]  rd_o;
    logic          out_valid;
    logic          out_ready;
    logic          out_id;
    logic [DW-1:0] out_data;
    logic          busy;

    // Counter bus models: each drives only while its strobe is high.
    logic [DW-1:0] v0, v1;
    bit            fixed_vals;
    assign bus_data = rd_o[0] ? v0 : (rd_o[1] ? v1 : 8'hzz);

    counter_bus_reader #(
        .N_SRC      (N),
        .DATA_W     (DW),
        .RD_CYCLES  (RD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .poll_en   (poll_en),
        .src_mask  (src_mask),
        .bus_data  (bus_data),
        .rd_o      (rd_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!fixed_vals) begin
            if (!rd_o[0]) v0 = DW'($urandom);
            if (!rd_o[1]) v1 = DW'($urandom);
        end
    end

    // Reference model: a strobe in flight, a quiet period after it, and a
    // one-entry output slot.
    int            m_rd_idx, m_strobe_left, m_quiet_left, m_ptr, m_sel, m_j;
    bit            m_full, m_xfer, m_free, m_can;
    int            m_id;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_exp_rd;

    // DUT output snapshot from the previous cycle, used to log transfers.
    bit            s_valid;
    logic          s_id;
    logic [DW-1:0] s_data;
    int            obs_id[$];
    logic [DW-1:0] obs_data[$];

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_rd_idx = -1; m_strobe_left = 0; m_quiet_left = 0;
            m_ptr = N - 1; m_full = 0; m_id = 0; m_data = '0; s_valid = 0;
        end else begin
            if (s_valid && out_ready) begin
                obs_id.push_back(int'(s_id));
                obs_data.push_back(s_data);
            end
            m_xfer = m_full && out_ready;
            m_free = !m_full || out_ready;
            if (m_xfer) m_full = 0;
            m_can = poll_en && (src_mask != 0) && m_free;
            if (m_rd_idx >= 0) begin
                m_strobe_left--;
                if (m_strobe_left == 0) begin
                    m_full = 1;
                    m_id = m_rd_idx;
                    m_data = (m_rd_idx == 0) ? v0 : v1;
                    m_ptr = m_rd_idx;
                    m_rd_idx = -1;
                    m_quiet_left = GAP;
                end
            end else begin
                if (m_quiet_left > 0) m_quiet_left--;
                if (m_quiet_left == 0 && m_can) begin
                    m_sel = -1;
                    for (int k = 1; k <= N; k++) begin
                        m_j = (m_ptr + k) % N;
                        if (m_sel < 0 && src_mask[m_j]) m_sel = m_j;
                    end
                    m_rd_idx = m_sel;
                    m_strobe_left = RD;
                end
            end
            #1;
            if (reset_b) begin
                m_exp_rd = (m_rd_idx < 0) ? '0 : N'(1 << m_rd_idx);
                cmp("model_rd_o", 32'(rd_o), 32'(m_exp_rd));
                cmp("model_out_valid", 32'(out_valid), 32'(m_full));
                cmp("model_busy", 32'(busy),
                    32'((m_rd_idx >= 0) || (m_quiet_left > 0) || m_full));
                if (m_full) begin
                    cmp("model_out_id", 32'(out_id), 32'(m_id));
                    cmp("model_out_data", 32'(out_data), 32'(m_data));
                end
                s_valid = out_valid;
                s_id = out_id;
                s_data = out_data;
            end
        end
    end

    // mode 0: rd_o==v, 1: rd_o!=0, 2: out_valid, 3: !busy
    task automatic wait_cond(input int mode, input logic [N-1:0] v, input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(posedge clk);
            #2;
            case (mode)
                0: hit = (rd_o == v);
                1: hit = (rd_o != 0);
                2: hit = out_valid;
                default: hit = !busy;
            endcase
        end
        cmp({"wait_", nm}, 32'(hit), 32'd1);
    endtask

    logic [N-1:0] rr_exp [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        reset_b = 0; poll_en = 0; src_mask = '0; out_ready = 0;
        fixed_vals = 1; v0 = 8'h05; v1 = 8'hA3;

        // Reset state.
        #140;
        cmp("rst_rd_o", 32'(rd_o), 0);
        cmp("rst_out_valid", 32'(out_valid), 0);
        cmp("rst_busy", 32'(busy), 0);
        @(negedge clk) reset_b = 1;
        repeat (10) begin
            @(posedge clk); #2;
            cmp("no_poll_rd_o", 32'(rd_o), 0);
        end

        // Round-robin with fixed counter values.
        @(negedge clk);
        src_mask = 2'b11; out_ready = 1; poll_en = 1;
        obs_id.delete(); obs_data.delete();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            cmp("rr_rd_seq", 32'(rd_o), 32'(rr_exp[k]));
        end
        repeat (4) @(posedge clk);
        #2;
        cmp("rr_count_ge3", 32'(obs_id.size() >= 3), 1);
        if (obs_id.size() >= 3) begin
            cmp("rr_id0", 32'(obs_id[0]), 0);
            cmp("rr_data0", 32'(obs_data[0]), 32'h05);
            cmp("rr_id1", 32'(obs_id[1]), 1);
            cmp("rr_data1", 32'(obs_data[1]), 32'hA3);
            cmp("rr_id2", 32'(obs_id[2]), 0);
            cmp("rr_data2", 32'(obs_data[2]), 32'h05);
        end

        // Single-source mask, then mask switch mid-read.
        @(negedge clk) poll_en = 0;
        wait_cond(3, '0, "idle_before_mask");
        @(negedge clk);
        src_mask = 2'b10; poll_en = 1;
        obs_id.delete(); obs_data.delete();
        repeat (12) @(posedge clk);
        #2;
        cmp("mask10_count_ge3", 32'(obs_id.size() >= 3), 1);
        foreach (obs_id[i]) cmp("mask10_id", 32'(obs_id[i]), 1);
        wait_cond(0, 2'b10, "mask10_read");
        @(negedge clk) src_mask = 2'b01;
        wait_cond(0, 2'b00, "mask_switch_gap");
        wait_cond(1, '0, "mask_switch_next");
        cmp("mask_switch_rd_o", 32'(rd_o), 32'b01);

        // Async reset mid-read, then backpressure from reset state.
        wait_cond(0, 2'b01, "rd0_before_reset");
        #20;
        reset_b = 0;
        #1;
        cmp("async_rst_rd_o", 32'(rd_o), 0);
        cmp("async_rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        reset_b = 1; src_mask = 2'b11; out_ready = 0; poll_en = 1;
        wait_cond(1, '0, "first_after_reset");
        cmp("first_after_reset_rd_o", 32'(rd_o), 32'b01);
        wait_cond(2, '0, "bp_valid");
        repeat (3) begin
            @(posedge clk); #2;
            cmp("bp_valid", 32'(out_valid), 1);
            cmp("bp_data", 32'(out_data), 32'h05);
            cmp("bp_id", 32'(out_id), 0);
            cmp("bp_rd_o", 32'(rd_o), 0);
            cmp("bp_busy", 32'(busy), 1);
        end
        @(negedge clk) out_ready = 1;
        @(posedge clk); #2;
        cmp("bp_release_rd_o", 32'(rd_o), 32'b10);
        cmp("bp_release_valid", 32'(out_valid), 0);
        @(negedge clk) out_ready = 0;
        @(negedge clk) out_ready = 1;

        // Idle conditions: empty mask, then poll_en dropped mid-read.
        @(negedge clk) poll_en = 0;
        wait_cond(3, '0, "idle_before_empty_mask");
        @(negedge clk);
        src_mask = 2'b00; poll_en = 1;
        repeat (8) begin
            @(posedge clk); #2;
            cmp("empty_mask_rd_o", 32'(rd_o), 0);
            cmp("empty_mask_busy", 32'(busy), 0);
        end
        @(negedge clk) src_mask = 2'b11;
        wait_cond(1, '0, "poll_drop_read");
        @(negedge clk);
        poll_en = 0;
        obs_id.delete(); obs_data.delete();
        repeat (10) @(posedge clk);
        #2;
        cmp("poll_drop_outputs", 32'(obs_id.size()), 1);
        cmp("poll_drop_busy", 32'(busy), 0);

        // Randomized traffic against the model.
        fixed_vals = 0;
        repeat (600) begin
            @(negedge clk);
            poll_en   = ($urandom % 8) != 0;
            src_mask  = N'($urandom);
            out_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);
        out_ready = 1; poll_en = 0;
        repeat (10) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_bus_reader.md
Name: counter_bus_reader

Overview:
Bus-side reader for counter instances that share one tristate data bus. Each counter drives the bus only while its read strobe is high. This block issues mutually exclusive, one-hot read strobes to the counters in round-robin order and samples the shared bus. It then presents each captured value with a source id on a valid/ready output. It sits at the top level next to the counters and guarantees that two counters never drive the bus at the same time.

Parameters:
N_SRC, 2, number of counters on the shared bus (2..8)
DATA_W, 8, shared data bus width
RD_CYCLES, 2, cycles each read strobe is held high (>=1); the bus is sampled on the last one
GAP_CYCLES, 1, bus-turnaround cycles with all strobes low between reads (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_b  input  1  reset, asynchronous, active-low
poll_en  input  1  polling enable; level-sensitive
src_mask  input  N_SRC  per-counter enable for polling; bit i=1 means counter i is polled
bus_data  input  DATA_W  shared tristate bus as seen by the reader
rd_o  output  N_SRC  read strobes, one per counter, one-hot or zero
out_valid  output  1  captured sample available
out_ready  input  1  consumer accepts sample
out_id  output  $clog2(N_SRC)  index of the counter that produced out_data
out_data  output  DATA_W  captured bus value
busy  output  1  high in READ, GAP or HOLD

Behaviour:
- Decided interface: one clock (clk); reset_b is asynchronous and active-low.
- Reset values: rd_o=0, out_valid=0, out_id=0, out_data=0, busy=0, state=IDLE, rr pointer=N_SRC-1 (so index 0 wins first). Asserting reset_b mid-read drops rd_o to 0 immediately, without waiting for a clock edge.
- FSM states:
  - IDLE: at a rising edge with poll_en=1, src_mask!=0 and the output slot free, select the next source and go to READ. rd_o[sel] is high in the following cycle.
  - READ: hold rd_o=onehot(sel) for exactly RD_CYCLES cycles. On the edge that ends the last READ cycle, do all of: out_data<=bus_data, out_id<=sel, out_valid<=1, rd_o<=0, pointer<=sel, go to GAP.
  - GAP: rd_o=0 for GAP_CYCLES cycles. At the end of GAP:
    - If the slot is free and poll_en=1 and mask!=0, go straight to READ for the next source (no IDLE cycle).
    - Else if the slot is not free, go to HOLD.
    - Else go to IDLE.
  - HOLD: rd_o=0. Wait until the slot is free, then apply the IDLE rules.
- Slot free means out_valid==0, or out_valid&&out_ready in that cycle (transfer and new selection can happen on the same edge).
- Output handshake: a transfer occurs when out_valid&&out_ready at a rising edge, which clears out_valid. out_data and out_id stay stable while out_valid=1 and out_ready=0. No sample is ever dropped or overwritten: a new read never starts while the slot is occupied.
- Round-robin selection: choose the lowest index > pointer with src_mask=1, wrapping modulo N_SRC. If only one bit is set, that source is selected repeatedly.
- Mask and enable changes: src_mask is sampled only at selection time; a change during READ does not abort the current read. Dropping poll_en mid-read also completes the read and its GAP; strobes are never truncated.
- Invariants:
  - rd_o is never multi-hot.
  - Between any two strobe pulses there are >=GAP_CYCLES cycles with rd_o=0.
  - rd_o is registered, with no combinational path from inputs.
- Throughput with out_ready=1: one sample per RD_CYCLES+GAP_CYCLES cycles (3 at defaults).

Decomposition:
- Package counter_bus_pkg:
  - FSM state encoding (IDLE, READ, GAP, HOLD)
  - default DATA_W and N_SRC constants
  - function onehot(idx)
- Sub-module rr_next_sel: purely combinational. Inputs: mask, pointer. Outputs: sel, found. Instantiated once.
- Read-length and gap timers share one down-counter sized for max(RD_CYCLES, GAP_CYCLES).

Test Plan:
Bench config: N_SRC=2, DATA_W=8, RD_CYCLES=2, GAP_CYCLES=1, 100 ns clock. Two bus models drive bus_data only while their strobe is high; bus_data is Z otherwise.
1. Reset: reset_b=0 for 150 ns -> rd_o=2'b00, out_valid=0, busy=0. Release with poll_en=0 -> no strobes for 10 cycles.
2. Round-robin: mask=2'b11, out_ready=1, counter0 drives 8'h05, counter1 drives 8'hA3 -> rd_o goes 01,01,00,10,10,00,... Outputs (id0,05),(id1,A3),(id0,05) one every 3 cycles. rd_o is never 2'b11; out_data is never X.
3. Mask: mask=2'b10 -> only rd_o[1] pulses, every out_id=1. Changing mask to 2'b01 during READ -> the current id1 read completes, the next read is id0.
4. Backpressure: out_ready=0 after the first capture -> out_valid stays 1, out_data=8'h05 stable, rd_o=00, busy=1 (HOLD). Raise out_ready for 1 cycle -> transfer, and rd_o=10 in the next cycle.
5. Async reset mid-read: pull reset_b low mid-cycle while rd_o=01 -> rd_o=00 before the next edge, out_valid=0; after release the first read is id0.
6. Idle conditions: poll_en=1 with mask=2'b00 -> no strobes, busy=0. poll_en dropped during READ -> that read completes, one output is produced, then IDLE.
